// File: rtl/radio_pkg.sv
// Shared widths, PWM mapping constants and the stream record type for the
// RC receiver controller.
package radio_pkg;

    localparam int unsigned VAL_W   = 10;
    localparam int unsigned CH_W    = 3;
    localparam int unsigned MAX_CH  = 8;
    localparam int unsigned WIDTH_W = 11;
    localparam int unsigned WD_W    = 16;

    localparam logic [WIDTH_W-1:0] PWM_OFFSET = 11'd987;
    localparam logic [WIDTH_W-1:0] PWM_MAX    = 11'd2010;
    localparam logic [WIDTH_W-1:0] WIDTH_SAT  = 11'd2047;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [VAL_W-1:0] val;
        logic             lost;
    } rec_t;

    // Pulse width in us to a 10-bit stick value, clamped at both ends.
    function automatic logic [VAL_W-1:0] pwm_map(input logic [WIDTH_W-1:0] w);
        logic [WIDTH_W-1:0] diff;
        logic [VAL_W-1:0]   res;
        diff = w - PWM_OFFSET;
        if (w < PWM_OFFSET) begin
            res = '0;
        end else if (w > PWM_MAX) begin
            res = '1;
        end else begin
            res = diff[VAL_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/radio_chan.sv
// One PWM input channel: synchroniser, width measurement, value mapping and
// signal-loss watchdog with failsafe substitution.
module radio_chan
    import radio_pkg::*;
#(
    parameter logic [VAL_W-1:0]   DEFAULT = 10'd512,
    parameter logic [WD_W-1:0]    TIMEOUT = 16'd50000,
    parameter logic [WIDTH_W-1:0] MIN_W   = 11'd500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    output logic [VAL_W-1:0] val_o,
    output logic             lost_o,
    output logic             cap_o,
    output logic             loss_c_o
);

    logic [2:0]         sync_q, sync_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [VAL_W-1:0]   cap_val_q, cap_val_d;
    logic               lost_q, lost_d;
    logic               cap_q, cap_d;
    logic               fall_c;
    logic               expire_c;

    // sync_q[1] is the synchronised pin, sync_q[2] its previous value
    assign fall_c   = sync_q[2] & ~sync_q[1];
    // a capture landing on the expiry clock wins over the loss
    assign expire_c = (wd_q == TIMEOUT - WD_W'(1)) && !lost_q && !cap_q;

    // Width measurement and staging of the mapped value
    always_comb begin
        sync_d    = {sync_q[1:0], sig_i};
        width_d   = width_q;
        cap_d     = 1'b0;
        cap_val_d = cap_val_q;
        if (fall_c) begin
            width_d = '0;
            if ((width_q >= MIN_W) && (width_q != WIDTH_SAT)) begin
                cap_d     = 1'b1;
                cap_val_d = pwm_map(width_q);
            end
        end else if (sync_q[1] && (width_q != WIDTH_SAT)) begin
            width_d = width_q + WIDTH_W'(1);
        end
    end

    // Live value, lost flag and watchdog
    always_comb begin
        wd_d   = wd_q;
        val_d  = val_q;
        lost_d = lost_q;
        if (cap_q) begin
            wd_d   = '0;
            val_d  = cap_val_q;
            lost_d = 1'b0;
        end else begin
            if (wd_q != TIMEOUT) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (expire_c) begin
                val_d  = DEFAULT;
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            width_q   <= '0;
            wd_q      <= '0;
            val_q     <= DEFAULT;
            cap_val_q <= '0;
            lost_q    <= 1'b1;
            cap_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            width_q   <= width_d;
            wd_q      <= wd_d;
            val_q     <= val_d;
            cap_val_q <= cap_val_d;
            lost_q    <= lost_d;
            cap_q     <= cap_d;
        end
    end

    assign val_o    = val_q;
    assign lost_o   = lost_q;
    assign cap_o    = cap_q;
    assign loss_c_o = expire_c;

endmodule

// File: rtl/radio_ctrl.sv
// Multi-channel RC receiver controller: per-channel capture, pending-event
// tracking and a round-robin valid/ready record stream.
module radio_ctrl
    import radio_pkg::*;
#(
    parameter int unsigned        NUM_CH  = 4,
    parameter logic [VAL_W-1:0]   DEFAULT = 10'd512,
    parameter logic [WD_W-1:0]    TIMEOUT = 16'd50000,
    parameter logic [WIDTH_W-1:0] MIN_W   = 11'd500
) (
    input  logic                    clk_1M,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       sig,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [VAL_W-1:0]        out_val,
    output logic                    out_lost,
    output logic [NUM_CH*VAL_W-1:0] vals,
    output logic [NUM_CH-1:0]       lost
);

    logic [VAL_W-1:0]  ch_val [MAX_CH];
    logic [MAX_CH-1:0] ch_lost;
    logic [MAX_CH-1:0] ch_cap;
    logic [MAX_CH-1:0] ch_loss;

    logic [MAX_CH-1:0] pend_q, pend_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    rec_t              rec_q, rec_d;

    logic [MAX_CH-1:0] grant_oh_c;
    logic              grant_vld_c;
    logic [CH_W-1:0]   grant_idx_c;
    logic [CH_W:0]     idx_c;
    logic              sched_c;

    // Channel slots beyond NUM_CH are tied off so the arbiter can index a fixed-size array
    for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            radio_chan #(
                .DEFAULT (DEFAULT),
                .TIMEOUT (TIMEOUT),
                .MIN_W   (MIN_W)
            ) u_chan (
                .clk_i    (clk_1M),
                .rst_i    (rst),
                .sig_i    (sig[i]),
                .val_o    (ch_val[i]),
                .lost_o   (ch_lost[i]),
                .cap_o    (ch_cap[i]),
                .loss_c_o (ch_loss[i])
            );
            assign vals[i*VAL_W +: VAL_W] = ch_val[i];
            assign lost[i]                = ch_lost[i];
        end else begin : g_off
            assign ch_val[i]  = '0;
            assign ch_lost[i] = 1'b0;
            assign ch_cap[i]  = 1'b0;
            assign ch_loss[i] = 1'b0;
        end
    end

    // First pending channel at or after rr_q, wrapping at NUM_CH
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        idx_c       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx_c = {1'b0, rr_q} + (CH_W+1)'(k);
            if (idx_c >= (CH_W+1)'(NUM_CH)) begin
                idx_c = idx_c - (CH_W+1)'(NUM_CH);
            end
            if (!grant_vld_c && pend_q[idx_c[CH_W-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx_c[CH_W-1:0];
            end
        end
    end

    assign sched_c = !out_valid_q || out_ready;

    // Output register load; a stalled record holds and blocks new grants
    always_comb begin
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        rr_d        = rr_q;
        grant_oh_c  = '0;
        if (sched_c) begin
            if (grant_vld_c) begin
                out_valid_d             = 1'b1;
                rec_d.ch                = grant_idx_c;
                rec_d.val               = ch_val[grant_idx_c];
                rec_d.lost              = ch_lost[grant_idx_c];
                grant_oh_c[grant_idx_c] = 1'b1;
                rr_d = (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Set after clear so a capture coinciding with its grant stays pending
    assign pend_d = (pend_q & ~grant_oh_c) | ch_cap | ch_loss;

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = rec_q.ch;
    assign out_val   = rec_q.val;
    assign out_lost  = rec_q.lost;

endmodule

// File: doc/radio_ctrl.md
Name: radio_ctrl

Overview:
Multi-channel RC receiver controller. Captures NUM_CH PWM servo inputs at 1 us resolution and maps each pulse width to a 10-bit value. Runs a per-channel signal-loss watchdog with failsafe substitution. A round-robin scheduler serialises fresh samples onto a single valid/ready stream for the flight-control logic, and a parallel snapshot of all channels is also provided.

Parameters:
NUM_CH, 4, number of PWM input channels (2..8)
DEFAULT, 10'd512, failsafe value loaded at reset and on signal loss
TIMEOUT, 16'd50000, clocks (us) without a valid pulse before a channel is declared lost
MIN_W, 11'd500, pulse widths below this are rejected as glitches

Ports:
clk_1M  in  1  1 MHz clock
rst  in  1  asynchronous, active-high reset
sig  in  NUM_CH  raw PWM inputs, asynchronous to clk_1M
out_valid  out  1  stream record valid
out_ready  in  1  consumer accepts record
out_ch  out  3  channel index of record
out_val  out  10  channel value of record
out_lost  out  1  channel lost flag of record
vals  out  NUM_CH*10  live value per channel, ch0 in bits [9:0]
lost  out  NUM_CH  live lost flag per channel

Behaviour:
- Reset (async, active-high): vals = DEFAULT on all channels, lost = all 1s, pending = 0, out_valid = 0, out_ch/out_val/out_lost = 0, rr pointer = 0, width and watchdog counters = 0.
- Input sync: 2-flop synchroniser per channel, then edge detect against a third flop. Falling edge is detected 3 clocks after the pin edge.
- Width counter (11 bits): counts while the synced input is high and saturates at 2047. Cleared on the cycle after a falling edge.
- Falling edge with width W:
  - Valid when MIN_W <= W < 2047.
  - Map: W < 987 -> 0; W > 2010 -> 1023; otherwise W - 987 (10-bit).
  - A valid pulse updates vals[ch] on the next clock, clears lost[ch], resets the watchdog and sets pending[ch].
  - An invalid pulse (glitch or saturated width) changes nothing.
- Watchdog (16 bits per channel): increments every clock and saturates at TIMEOUT. When it reaches TIMEOUT while lost[ch] = 0:
  - lost[ch] <= 1
  - vals[ch] <= DEFAULT
  - pending[ch] <= 1 (exactly one loss event per transition)
- Scheduler, run when out_valid = 0 or (out_valid & out_ready):
  - Grant the first pending channel searching from rr upward, with wrap-around.
  - Load out_ch/out_val/out_lost from that channel's current state and set out_valid = 1 on the next clock.
  - Clear pending[granted]; set rr = granted + 1 (mod NUM_CH).
  - If nothing is pending, out_valid <= 0.
- Handshake: while out_valid & !out_ready, out_* hold stable and no grant occurs.
  - Back-to-back records are allowed: a handshake cycle may load the next record in the same clock.
- Simultaneous set and clear: a capture on the same clock as its channel's grant leaves pending set. The newer value is emitted in a later record and is not dropped.
- Coalescing: multiple captures on a channel while a record is stalled collapse into one record carrying the latest value.
- Latency: a valid falling edge at the pin reaches vals in 4 clocks, and out_valid in at most 5 clocks when the stream is idle.

Decomposition:
- radio_pkg:
  - PWM_OFFSET = 987, PWM_MAX = 2010, WIDTH_SAT = 2047
  - record field widths
  - map function (width -> 10-bit value)
- Sub-module radio_chan, one instance per channel, containing:
  - synchroniser and edge detect
  - width counter, map and watchdog
  - outputs: val, lost, capture strobe, loss strobe
- radio_ctrl contains the generate loop, the pending vector, the round-robin arbiter and the output register.

Test Plan:
1. Reset, then out_ready = 1 and a 1500 us pulse on ch0 -> vals[0] = 513, lost[0] = 0, one record {ch=0, val=513, lost=0}.
2. Pulses of 900, 2100 and 300 us on ch1 -> records with val = 0 then val = 1023. The 300 us glitch produces no record and vals[1] stays 1023.
3. out_ready = 0 with 1200/1300/1800 us pulses on ch0, ch1 and ch2 at the same time -> out_* stay frozen on the first grant. Releasing ready gives records in order ch0 = 213, ch1 = 313, ch2 = 813, with no gaps between them.
4. Stall, then two successive pulses of 1100 then 1600 us on ch3 -> exactly one ch3 record with val = 613.
5. Valid pulses on ch2 followed by silence for 50000 clocks -> lost[2] = 1, vals[2] = 512, one record {ch=2, val=512, lost=1}. A further 1500 us pulse clears lost and emits val = 513.
6. Assert rst while out_valid = 1 during a pulse -> all outputs return to reset values immediately. The pulse that was in progress is not captured.
